// File: rtl/fltadd_job_sequencer.sv
// fltadd_job_sequencer
//   Sequences half-precision float-add jobs through the top_level program
//   core. Operand pairs are queued in a small FIFO; for each job the core is
//   reset, operands are written to data-memory bytes 8..11, the core is
//   started and watched for ack (or abandoned after TIMEOUT RUN cycles), and
//   the result bytes 13/12 are read back and offered on a valid/ready port.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   job_valid/ready     job request handshake, job_op1/job_op2 operands
//   core_reset/start    drive the core's reset and start, core_ack from core
//   mem_sel             1 = sequencer owns the data-memory port
//   mem_we/addr/wdata   sequencer-side memory write/address
//   mem_rdata           combinational read data for mem_addr
//   res_valid/ready     result handshake; res_data, res_timeout, res_cycles
//   busy                sequencer active or jobs queued
module fltadd_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_op1,
  input  logic [15:0] job_op2,
  output logic        core_reset,
  output logic        core_start,
  input  logic        core_ack,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_timeout,
  output logic [15:0] res_cycles,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [15:0] TMO      = TIMEOUT[15:0];

  typedef enum logic [2:0] {
    IDLE, CRST, LOAD, START, RUN, RDHI, RDLO, OUT
  } state_t;

  state_t state, state_nxt;

  // Job FIFO
  logic [31:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop;

  // Working registers
  logic [15:0] op1, op2;
  logic [1:0]  bcnt, bcnt_nxt;
  logic [15:0] cyc, cyc_nxt;

  logic [15:0] res_data_nxt, res_cycles_nxt;
  logic        res_timeout_nxt;

  logic        core_reset_nxt, core_start_nxt, mem_sel_nxt, mem_we_nxt;
  logic [7:0]  mem_addr_nxt, mem_wdata_nxt;

  always_comb begin
    push = job_valid & job_ready;
    pop  = (state == IDLE) && (count != '0);

    case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Next-state and result-register logic
  always_comb begin
    state_nxt       = state;
    bcnt_nxt        = bcnt;
    cyc_nxt         = cyc;
    res_data_nxt    = res_data;
    res_timeout_nxt = res_timeout;
    res_cycles_nxt  = res_cycles;

    case (state)
      IDLE:  if (pop) state_nxt = CRST;
      CRST:  state_nxt = LOAD;
      LOAD: begin
        bcnt_nxt = bcnt + 2'd1;
        if (bcnt == 2'd3) state_nxt = START;
      end
      START: begin
        cyc_nxt   = '0;
        state_nxt = RUN;
      end
      RUN: begin
        cyc_nxt = (cyc == TMO) ? cyc : cyc + 16'd1;
        // ack in the final allowed cycle still counts as a completion
        if (core_ack) begin
          state_nxt      = RDHI;
          res_cycles_nxt = cyc + 16'd1;
        end else if (cyc + 16'd1 == TMO) begin
          state_nxt       = OUT;
          res_timeout_nxt = 1'b1;
          res_data_nxt    = 16'h7E00;
          res_cycles_nxt  = TMO;
        end
      end
      RDHI: begin
        res_data_nxt[15:8] = mem_rdata;
        state_nxt          = RDLO;
      end
      RDLO: begin
        res_data_nxt[7:0] = mem_rdata;
        res_timeout_nxt   = 1'b0;
        state_nxt         = OUT;
      end
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered outputs line
  // up with the state register rather than lagging it by a cycle.
  always_comb begin
    core_reset_nxt = 1'b0;
    core_start_nxt = 1'b0;
    mem_sel_nxt    = 1'b1;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = '0;
    mem_wdata_nxt  = '0;

    case (state_nxt)
      IDLE, CRST: core_reset_nxt = 1'b1;
      LOAD: begin
        mem_we_nxt   = 1'b1;
        mem_addr_nxt = 8'd8 + {6'd0, bcnt_nxt};
        case (bcnt_nxt)
          2'd0:    mem_wdata_nxt = op1[7:0];
          2'd1:    mem_wdata_nxt = op1[15:8];
          2'd2:    mem_wdata_nxt = op2[7:0];
          default: mem_wdata_nxt = op2[15:8];
        endcase
      end
      START: begin
        core_start_nxt = 1'b1;
        mem_sel_nxt    = 1'b0;
      end
      RUN:     mem_sel_nxt  = 1'b0;
      RDHI:    mem_addr_nxt = 8'd13;
      RDLO:    mem_addr_nxt = 8'd12;
      default: ;
    endcase
  end

  // FIFO storage carries no reset; the pointers define its contents
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {job_op1, job_op2};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      op1         <= '0;
      op2         <= '0;
      bcnt        <= '0;
      cyc         <= '0;
      res_data    <= '0;
      res_timeout <= 1'b0;
      res_cycles  <= '0;
      res_valid   <= 1'b0;
      core_reset  <= 1'b1;
      core_start  <= 1'b0;
      mem_sel     <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      job_ready   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        {op1, op2} <= fifo_mem[rd_ptr];
      end
      bcnt        <= bcnt_nxt;
      cyc         <= cyc_nxt;
      res_data    <= res_data_nxt;
      res_timeout <= res_timeout_nxt;
      res_cycles  <= res_cycles_nxt;
      res_valid   <= (state_nxt == OUT);
      core_reset  <= core_reset_nxt;
      core_start  <= core_start_nxt;
      mem_sel     <= mem_sel_nxt;
      mem_we      <= mem_we_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      job_ready   <= (count_nxt != FULL_CNT);
      busy        <= (state_nxt != IDLE) || (count_nxt != '0);
    end
  end

endmodule

// File: doc/fltadd_job_sequencer.md
# fltadd_job_sequencer

Hardware job sequencer for the half-precision float-add program core (`top_level`). It accepts operand pairs from a requester through a small FIFO and, for each job, does the following:
- resets the core and writes the operands into its data memory (bytes 8–11);
- pulses `start` and waits for the core's `ack`;
- reads the result back from bytes 12–13 and presents it, with a cycle count, on a valid/ready result port.

It replaces testbench-driven sequencing when the core is embedded in a larger system, and owns the data-memory port whenever the core is not running.

## Interface
Parameters:
- `DEPTH`, 4: job FIFO entries (power of 2, ≥2).
- `TIMEOUT`, 2048: maximum RUN cycles before the job is abandoned (≤65535).

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high.
- `job_valid`  in  1  requester offers a job.
- `job_ready`  out  1  FIFO not full; the job is accepted when `job_valid & job_ready` at a rising edge.
- `job_op1`  in  16  first operand (IEEE half).
- `job_op2`  in  16  second operand.
- `core_reset`  out  1  drives the core's `reset`.
- `core_start`  out  1  drives the core's `start`.
- `core_ack`  in  1  the core's `ack`.
- `mem_sel`  out  1  1 = sequencer owns the data-memory port; 0 = core owns it (external mux).
- `mem_we`  out  1  byte write enable.
- `mem_addr`  out  8  byte address.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data, combinational from `mem_addr` (same cycle).
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  16  result {mem[13], mem[12]}, or 16'h7E00 on timeout.
- `res_timeout`  out  1  job was abandoned.
- `res_cycles`  out  16  RUN cycles consumed by the job.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- **FIFO:** DEPTH×32 storage {op1, op2}.
  - `job_ready = !full`, from registered state.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - When full, `job_ready` stays 0 even during a pop cycle.
- **States:** IDLE, CRST, LOAD, START, RUN, RDHI, RDLO, OUT.
- **IDLE:** if the FIFO is non-empty, pop the head into the op registers and go to CRST. Otherwise stay.
- **CRST:** one cycle; `core_reset`=1, `mem_sel`=1. Go to LOAD.
- **LOAD:** four cycles; `mem_sel`=1, `mem_we`=1. Writes in this order:
  - addr 8 ← op1[7:0]
  - addr 9 ← op1[15:8]
  - addr 10 ← op2[7:0]
  - addr 11 ← op2[15:8]
  - A 2-bit byte counter selects the write and wraps to 0 on exit. Then go to START.
- **START:** one cycle; `core_start`=1, `mem_sel`=0. Clear the cycle counter and go to RUN.
- **RUN:** `mem_sel`=0. The counter increments every cycle and saturates at TIMEOUT.
  - If `core_ack`=1: go to RDHI. `res_cycles` = counter+1.
  - Else if counter+1 == TIMEOUT: go to OUT with `res_timeout`=1, `res_data`=16'h7E00, `res_cycles`=TIMEOUT.
  - `core_ack` is sampled only in RUN and ignored in all other states.
- **RDHI:** `mem_sel`=1, `mem_addr`=13; capture `res_data[15:8]`. Go to RDLO.
- **RDLO:** `mem_sel`=1, `mem_addr`=12; capture `res_data[7:0]`. `res_timeout`=0. Go to OUT.
- **OUT:** `res_valid`=1. `res_data`, `res_timeout` and `res_cycles` are held stable. On `res_ready`, go to IDLE. No new job starts until the result is consumed.
- **Idle defaults:**
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_start`=0.
  - `core_reset`=1 in IDLE and CRST, 0 otherwise (the core is held in reset while idle).
- All outputs are registered.

## Timing
- **Reset values:**
  - `core_reset`=1, `mem_sel`=1.
  - All other outputs 0, including `job_ready`=0 while `reset`=1.
  - FIFO empty, state IDLE.
  - `job_ready` rises the first cycle after `reset` deasserts.
- **Reset mid-operation, any state:** the next edge forces IDLE, the FIFO is flushed, and the in-flight job is discarded with no result. `core_reset` returns to 1 and `core_start`/`mem_we` drop immediately.
- **Latency from a job accepted into an empty, idle FIFO (edge E):**
  - IDLE pops at E+1.
  - CRST at E+2.
  - LOAD at E+3..E+6.
  - START at E+7.
  - RUN from E+8.
  - With the ack seen in RUN cycle N: RDHI = N+1, RDLO = N+2, `res_valid` rises at N+3.
- **Job-to-job gap:** minimum 1 IDLE cycle after OUT handshake.

## Test plan
- **Single job:** op1=op2=16'h1A04; the core model acks 20 RUN cycles after start with mem[13:12]=16'h1E04.
  - Writes observed: 8←04, 9←1A, 10←04, 11←1A, then one `core_start` pulse.
  - `res_data`=16'h1E04, `res_cycles`=20, `res_timeout`=0.
- **Queue fill:** push 5 jobs back-to-back while the first is RUNning, DEPTH=4.
  - `job_ready`=0 after 4 are queued, with the 5th presented only when space is available.
  - All 5 results emerge in push order.
- **Timeout:** TIMEOUT=64, the core never acks.
  - `res_timeout`=1, `res_data`=16'h7E00, `res_cycles`=64.
  - The next queued job then completes normally with a fresh CRST.
- **Back-pressure:** hold `res_ready`=0 for 10 cycles in OUT.
  - `res_valid` stays 1 and the data stays stable.
  - No CRST or `mem_we` activity occurs for the pending queued job until the handshake.
- **Reset during RUN:**
  - Next cycle: state IDLE, `core_reset`=1, `core_start`=0, `res_valid`=0, FIFO empty, `busy`=0.
  - A stale `core_ack` afterwards is ignored.
- **Simultaneous push/pop:** with the FIFO holding 1 entry, push in the same cycle IDLE pops.
  - The count stays 1 and the ordering is preserved.
